// File: rtl/linear_regression_predictor.sv
// Streaming y = theta0 + theta1*x predictor: 2-stage multiply/add pipeline feeding an output FIFO,
// with frame-boundary model updates. Define LR_PREDICTOR_SAT_EN to clamp instead of wrap.
module linear_regression_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_theta0_in,
  input  logic [DATA_WIDTH-1:0] i_theta1_in,
  input  logic                  i_theta_vld,
  input  logic [DATA_WIDTH-1:0] i_x_in,
  input  logic                  i_x_vld,
  output logic                  o_x_rdy,
  input  logic                  i_x_last,
  output logic [DATA_WIDTH-1:0] o_y_out,
  output logic                  o_y_vld,
  input  logic                  i_y_rdy,
  output logic                  o_y_last,
  output logic                  o_sat,
  output logic                  o_frame_done
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  // Wrap build keeps only the low DW bits: they equal the low bits of the full-width product and sum.
`ifdef LR_PREDICTOR_SAT_EN
  localparam int SW = 2 * DW;
`else
  localparam int SW = DW;
`endif

  typedef enum logic [1:0] {NOMODEL, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [DW-1:0] y;
    logic          last;
    logic          sat;
  } res_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   theta0_q, theta0_d, theta1_q, theta1_d;
  logic [DW-1:0]   sh0_q, sh0_d, sh1_q, sh1_d;
  logic            pend_q, pend_d;
  logic [1:0]      vld_pipe_q, vld_pipe_d;
  logic [SW-1:0]   prod_q, prod_d;
  logic [DW-1:0]   t0_pipe_q, t0_pipe_d;
  logic            last1_q, last1_d;
  res_t            res_q, res_d;
  res_t            mem_q [FIFO_DEPTH];
  res_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [OW-1:0]   occ;
  logic            x_fire, drained, push, pop;
  logic [SW-1:0]   sum;
  res_t            head;

  always_comb begin
    occ          = OW'(cnt_q) + OW'(vld_pipe_q[0]) + OW'(vld_pipe_q[1]);
    o_x_rdy      = (state_q == RUN) && (occ < OW'(FIFO_DEPTH));
    x_fire       = i_x_vld && o_x_rdy;
    drained      = (vld_pipe_q == 2'b00) && (cnt_q == '0);
    o_frame_done = (state_q == DRAIN) && drained;
    o_y_vld      = (cnt_q != '0);
    push         = vld_pipe_q[1];
    pop          = o_y_vld && i_y_rdy;
    head         = mem_q[rd_q];
    o_y_out      = o_y_vld ? head.y : '0;
    o_y_last     = o_y_vld && head.last;
    o_sat        = o_y_vld && head.sat;
  end

  // Model control: new thetas only take effect once the frame has fully drained.
  always_comb begin
    state_d  = state_q;
    theta0_d = theta0_q;
    theta1_d = theta1_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    pend_d   = pend_q;
    case (state_q)
      NOMODEL: if (i_theta_vld) begin
        theta0_d = i_theta0_in;
        theta1_d = i_theta1_in;
        state_d  = RUN;
      end
      RUN:     if (x_fire && i_x_last) state_d = DRAIN;
      DRAIN:   if (drained) begin
        state_d = RUN;
        pend_d  = 1'b0;
        if (pend_q) begin
          theta0_d = sh0_q;
          theta1_d = sh1_q;
        end
      end
      default: state_d = NOMODEL;
    endcase
    if (i_theta_vld && state_q != NOMODEL) begin
      if (state_q == DRAIN && drained) begin
        theta0_d = i_theta0_in;
        theta1_d = i_theta1_in;
        pend_d   = 1'b0;
      end else begin
        sh0_d  = i_theta0_in;
        sh1_d  = i_theta1_in;
        pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], x_fire};
    prod_d     = SW'(signed'(i_x_in)) * SW'(signed'(theta1_q));
    t0_pipe_d  = theta0_q;
    last1_d    = x_fire && i_x_last;
    sum        = prod_q + SW'(signed'(t0_pipe_q));
    res_d.last = last1_q;
`ifdef LR_PREDICTOR_SAT_EN
    if (sum[SW-1:DW-1] == '0 || sum[SW-1:DW-1] == '1) begin
      res_d.y   = sum[DW-1:0];
      res_d.sat = 1'b0;
    end else begin
      res_d.y   = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      res_d.sat = 1'b1;
    end
`else
    res_d.y    = sum;
    res_d.sat  = 1'b0;
`endif
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = res_q;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= NOMODEL;
      theta0_q   <= '0;
      theta1_q   <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      pend_q     <= 1'b0;
      vld_pipe_q <= '0;
      prod_q     <= '0;
      t0_pipe_q  <= '0;
      last1_q    <= 1'b0;
      res_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      theta0_q   <= theta0_d;
      theta1_q   <= theta1_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      pend_q     <= pend_d;
      vld_pipe_q <= vld_pipe_d;
      prod_q     <= prod_d;
      t0_pipe_q  <= t0_pipe_d;
      last1_q    <= last1_d;
      res_q      <= res_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
